// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared FSM type and CRC16 constants for the USB TX framer
package usb_tx_pkg;
  typedef enum logic [2:0] {IDLE, PAYLOAD, LAST_WAIT, CRC_LO, CRC_HI} tx_state_t;
  localparam logic [15:0] CRC16_POLY_REF = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam int MAX_PKT_DEFAULT = 64;
endpackage

// File: rtl/crc16_byte.sv
// crc16_byte: one-byte reflected CRC16 (0xA001) update, LSB first, combinational
// Ports: crc_in running CRC, data next byte, crc_out updated CRC.
module crc16_byte import usb_tx_pkg::*; (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++)
      crc_out = (crc_out[0] ^ data[i]) ? (crc_out >> 1) ^ CRC16_POLY_REF : crc_out >> 1;
  end
endmodule

// File: rtl/tx_crc_appender.sv
// tx_crc_appender: forwards payload bytes through a one-entry holding register and appends ~CRC16 (low byte first)
module tx_crc_appender import usb_tx_pkg::*; #(
  parameter int MAX_PKT = MAX_PKT_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       flush,
  input  logic       tx_start,
  input  logic       zlp,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ack,
`ifdef TX_LEN_CHECK_EN
  output logic       len_err,
`endif
  output logic       tx_done
);
  tx_state_t state, state_nxt;
  logic [15:0] crc, crc_upd;
  logic xfer, ack, at_max;
  crc16_byte u_crc (.crc_in(crc), .data(tx_data), .crc_out(crc_upd));
  assign xfer = tx_valid && tx_ready;
  assign ack = byte_ack && byte_valid;
`ifdef TX_LEN_CHECK_EN
  logic [6:0] cnt;
  assign at_max = cnt == 7'(MAX_PKT - 1);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cnt <= '0;
      len_err <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= xfer && at_max && !tx_last;
      cnt <= (state == IDLE && tx_start) ? 7'd0 : xfer ? cnt + 7'd1 : cnt;
    end
`else
  assign at_max = 1'b0;
`endif
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (tx_start) state_nxt = zlp ? CRC_LO : PAYLOAD;
      PAYLOAD:   if (xfer && (tx_last || at_max)) state_nxt = LAST_WAIT;
      LAST_WAIT: if (ack) state_nxt = CRC_LO;
      CRC_LO:    if (ack) state_nxt = CRC_HI;
      CRC_HI:    if (ack) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end
  always_comb tx_ready = (state == PAYLOAD) && !byte_valid;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      byte_out <= 8'h00;
      byte_valid <= 1'b0;
      crc <= CRC16_INIT;
      tx_done <= 1'b0;
    end else if (flush) begin
      byte_valid <= 1'b0;
      crc <= CRC16_INIT;
      tx_done <= 1'b0;
    end else begin
      tx_done <= state == CRC_HI && ack;
      case (state)
        IDLE: if (tx_start) begin
          crc <= CRC16_INIT;
          if (zlp) begin
            byte_out <= 8'h00;
            byte_valid <= 1'b1;
          end
        end
        PAYLOAD: if (xfer) begin
          byte_out <= tx_data;
          byte_valid <= 1'b1;
          crc <= crc_upd;
        end else if (ack) byte_valid <= 1'b0;
        LAST_WAIT: if (ack) byte_out <= ~crc[7:0];
        CRC_LO:    if (ack) byte_out <= ~crc[15:8];
        CRC_HI:    if (ack) byte_valid <= 1'b0;
        default:   byte_valid <= 1'b0;
      endcase
    end
endmodule

// File: tb/tb_tx_crc_appender.sv
// tb_tx_crc_appender: randomized packets against a queue-based CRC16 reference model
module tb_tx_crc_appender;
  localparam int MAXP = 64;
  logic clk = 0, n_rst = 0, flush = 0, tx_start = 0, zlp = 0;
  logic tx_valid = 0, tx_last = 0, byte_ack = 0;
  logic [7:0] tx_data = 0, byte_out;
  logic tx_ready, byte_valid, tx_done, len_err;
  int n_cmp = 0, n_bad = 0;
  byte unsigned got[$];
  int done_cnt, ready_cnt, lerr_cnt, stall_bad;
  always #5 clk = ~clk;
  tx_crc_appender #(.MAX_PKT(MAXP)) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush), .tx_start(tx_start), .zlp(zlp),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ack(byte_ack),
`ifdef TX_LEN_CHECK_EN
    .len_err(len_err),
`endif
    .tx_done(tx_done)
  );
`ifndef TX_LEN_CHECK_EN
  assign len_err = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] crc16(input byte unsigned q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) for (int b = 0; b < 8; b++) c = (c[0] ^ q[i][b]) ? (c >> 1) ^ 16'hA001 : c >> 1;
    return c;
  endfunction
  task automatic gen(input int n, output byte unsigned q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask
  task automatic compare_out(input byte unsigned pl[$], input string tag);
    byte unsigned p[$];
    logic [15:0] c;
    p = pl;
`ifdef TX_LEN_CHECK_EN
    if (p.size() > MAXP) p = p[0:MAXP-1];
`endif
    c = ~crc16(p);
    p.push_back(c[7:0]);
    p.push_back(c[15:8]);
    check($sformatf("%s_count", tag), got.size(), p.size());
    foreach (p[i]) if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), got[i], p[i]);
  endtask
  task automatic send(input byte unsigned pl[$], input bit z, input int gap, input int stall_at,
                      input int abort_at, input int kind);
    int idx = 0, wait_n = 0;
    bit stalled = 0;
    logic [7:0] held;
    logic [15:0] c;
    got.delete();
    done_cnt = 0; ready_cnt = 0; lerr_cnt = 0; stall_bad = 0;
    tx_start = 1; zlp = z;
    for (int cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
      @(negedge clk);
      tx_start = 0; zlp = 0; byte_ack = 0; tx_valid = 0; tx_last = 0;
      done_cnt += int'(tx_done); lerr_cnt += int'(len_err); ready_cnt += int'(tx_ready);
      if (kind == 1 && got.size() == abort_at && byte_valid) begin
        c = ~crc16(pl);
        check("flush_crc_lo_present", byte_out, c[7:0]);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_valid", byte_valid, 0);
        check("flush_ready", tx_ready, 0);
        done_cnt = int'(tx_done);
        repeat (5) begin @(negedge clk); done_cnt += int'(tx_done); end
        check("flush_no_done", done_cnt, 0);
        return;
      end
      if (kind == 2 && got.size() == abort_at) begin
        #2 n_rst = 0;
        #1;
        check("rst_valid", byte_valid, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_done", tx_done, 0);
        check("rst_byte", byte_out, 0);
        check("rst_lerr", len_err, 0);
        @(negedge clk);
        n_rst = 1;
        return;
      end
      if (idx < pl.size()) begin
        tx_valid = 1; tx_data = pl[idx]; tx_last = idx == pl.size() - 1;
        if (tx_ready) idx++;
      end
      if (stall_at >= 0 && !stalled && got.size() == stall_at && byte_valid) begin
        stalled = 1;
        held = byte_out;
        repeat (20) begin
          @(negedge clk);
          stall_bad += int'(tx_ready || byte_out !== held || !byte_valid);
        end
      end
      if (byte_valid) begin
        if (wait_n == 0) begin
          byte_ack = 1;
          got.push_back(byte_out);
          wait_n = gap >= 0 ? gap : int'($urandom_range(3, 0));
        end else wait_n--;
      end
    end
  endtask
  initial begin
    byte unsigned pl[$];
    int n;
    repeat (3) @(negedge clk);
    check("reset_valid", byte_valid, 0);
    check("reset_ready", tx_ready, 0);
    check("reset_done", tx_done, 0);
    check("reset_byte", byte_out, 0);
    check("reset_lerr", len_err, 0);
    n_rst = 1;
    @(negedge clk);
    pl = {};
    send(pl, 1, 2, -1, -1, 0);
    compare_out(pl, "zlp");
    check("zlp_done", done_cnt, 1);
    check("zlp_ready", ready_cnt, 0);
    pl = {8'h00, 8'h01, 8'h02, 8'h03};
    send(pl, 0, -1, -1, -1, 0);
    compare_out(pl, "four");
    check("four_done", done_cnt, 1);
    check("four_residual", crc16(got), 16'hB001);
    check("four_lerr", lerr_cnt, 0);
    gen(8, pl);
    send(pl, 0, 0, 3, -1, 0);
    check("stall_hold", stall_bad, 0);
    compare_out(pl, "stall");
    check("stall_done", done_cnt, 1);
    gen(3, pl);
    send(pl, 0, 1, -1, 3, 1);
    gen(1, pl);
    send(pl, 0, -1, -1, -1, 0);
    compare_out(pl, "after_flush");
    check("after_flush_done", done_cnt, 1);
    gen(6, pl);
    send(pl, 0, 1, -1, 2, 2);
    gen(5, pl);
    send(pl, 0, -1, -1, -1, 0);
    compare_out(pl, "after_reset");
    check("after_reset_done", done_cnt, 1);
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(20, 0));
      gen(n, pl);
      send(pl, n == 0, -1, -1, -1, 0);
      compare_out(pl, $sformatf("rnd%0d", k));
      check($sformatf("rnd%0d_done", k), done_cnt, 1);
    end
    gen(70, pl);
    send(pl, 0, -1, -1, -1, 0);
    compare_out(pl, "long");
    check("long_done", done_cnt, 1);
`ifdef TX_LEN_CHECK_EN
    check("long_len_err", lerr_cnt, 1);
`else
    check("long_no_len_err", lerr_cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tx_crc_appender.md
# tx_crc_appender

Transmit-side payload framer for the USB full-speed data path. It sits between the TX data FIFO and the byte serializer. It accepts payload bytes over a valid/ready handshake and forwards them one at a time through a single-entry holding register. After the last payload byte it appends the two CRC16 bytes, low byte first. It is the counterpart of the receive path, which holds back the trailing two bytes so the CRC is stripped.

## Interface
- MAX_PKT, 64: maximum payload bytes per packet; used only when length checking is compiled in.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to idle.
- tx_start  in  1  one-cycle pulse that opens a packet; ignored outside IDLE.
- zlp  in  1  sampled with tx_start; 1 = zero-length packet, so only the CRC bytes are sent.
- tx_data  in  8  payload byte.
- tx_valid  in  1  tx_data is valid.
- tx_last  in  1  qualifies tx_data as the final payload byte.
- tx_ready  out  1  the block accepts tx_data this cycle.
- byte_out  out  8  byte presented to the serializer.
- byte_valid  out  1  byte_out is held and valid.
- byte_ack  in  1  one-cycle pulse from the serializer; it has taken byte_out.
- tx_done  out  1  one-cycle pulse after the CRC high byte is acknowledged.
- len_err  out  1  one-cycle pulse on payload overrun; exists only when length checking is compiled in.

## Operation
- States: IDLE, PAYLOAD, LAST_WAIT, CRC_LO, CRC_HI.
- CRC16 definition: polynomial 0x8005, processed reflected (0xA001), LSB-first, initial value 0xFFFF. Transmitted value is ~crc: low byte first, then high byte.
- IDLE:
  - tx_start=1, zlp=0: crc ← 0xFFFF; go to PAYLOAD.
  - tx_start=1, zlp=1: byte_out ← 0x00, byte_valid ← 1; go to CRC_LO. The high CRC byte is also 0x00.
- Transfer rule: a transfer occurs when tx_valid && tx_ready.
- tx_ready = (state==PAYLOAD) && !byte_valid. It is never asserted in any other state.
- PAYLOAD:
  - Transfer: byte_out ← tx_data, byte_valid ← 1, crc ← crc16_byte(crc, tx_data). If tx_last, go to LAST_WAIT.
  - byte_ack while byte_valid: byte_valid ← 0.
- LAST_WAIT, on byte_ack: byte_out ← ~crc[7:0], byte_valid stays 1; go to CRC_LO.
- CRC_LO, on byte_ack: byte_out ← ~crc[15:8]; go to CRC_HI.
- CRC_HI, on byte_ack: byte_valid ← 0, tx_done ← 1 for one cycle; go to IDLE.
- byte_ack is ignored while byte_valid=0.
- tx_start is ignored in any state other than IDLE.
- tx_valid is ignored outside PAYLOAD.
- flush has priority over every other input:
  - state ← IDLE, byte_valid ← 0, crc ← 0xFFFF.
  - No tx_done pulse; len_err is cleared.
- Reset mid-packet: asynchronous return to the reset values below; the packet is abandoned.

## Timing
- Reset values: state IDLE, byte_out 0x00, byte_valid 0, tx_ready 0, tx_done 0, len_err 0, crc 0xFFFF.
- Latency: payload accepted at edge k → byte_valid=1 with that byte from k+1.
- The CRC update is combinational on tx_data and registered at the same edge.
- Throughput: at most one payload byte per two cycles, because the holding register must drain before tx_ready reasserts.
- Byte boundaries: the CRC low byte is loaded at the edge where the last payload byte is acknowledged, with no idle gap. The CRC high byte is likewise loaded at the low byte's ack edge.
- tx_done asserts in the cycle after the CRC-high ack edge; IDLE is entered at that same edge.
- A back-to-back tx_start is accepted on the cycle tx_done is high.

## Configuration
- TX_LEN_CHECK_EN defined:
  - A 7-bit payload counter is added; it resets on tx_start.
  - When byte MAX_PKT is accepted without tx_last, it is treated as last: the block goes to LAST_WAIT and len_err pulses once.
  - Further upstream bytes up to and including tx_last are not forwarded. They are dropped by the upstream FIFO drain logic; tx_ready stays 0.
- TX_LEN_CHECK_EN undefined:
  - No counter and no len_err port.
  - Payload length is unbounded.

## Structure
- Package usb_tx_pkg contains:
  - the state enum typedef;
  - CRC16_POLY_REF = 16'hA001;
  - CRC16_INIT = 16'hFFFF;
  - MAX_PKT_DEFAULT = 64.
- Sub-module crc16_byte: combinational, inputs crc_in[15:0] and data[7:0], output crc_out[15:0], eight unrolled reflected shift steps. It is shared with the receive-side checker.

## Test plan
- ZLP: tx_start with zlp=1, byte_ack every 3 cycles → byte_out 0x00, then 0x00; tx_done once; tx_ready never asserted.
- Four-byte packet 0x00,0x01,0x02,0x03 with tx_last on 0x03 → six bytes out, payload unchanged. The last two bytes equal a golden-model ~CRC16, low first. The bench's crc16_byte run over all six bytes gives residual 0xB001.
- Serializer stall: hold byte_ack low for 20 cycles mid-payload → tx_ready stays 0, byte_out is stable, no byte is lost or duplicated.
- flush asserted in CRC_LO → next cycle IDLE, byte_valid 0, no tx_done. A following 1-byte packet produces a correct CRC.
- Async reset asserted mid-PAYLOAD → all outputs take their reset values immediately; the next packet is correct.
- With TX_LEN_CHECK_EN and MAX_PKT=64: 70-byte stream → 64 payload bytes plus 2 CRC bytes out, len_err pulses once, tx_done once.
